// File: rtl/uart_send.sv
// UART transmitter: start bit, eight data bits LSB first, optional parity
// bit, one stop bit. The bit period is chosen from Baud_set when a request
// is accepted and held for the whole frame.
module uart_send #(
  parameter int PARITY = 0
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [2:0] Baud_set,
  input  logic [7:0] Data,
  input  logic       send_en,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Parity values other than 1 (odd) or 2 (even) mean no parity bit.
  localparam bit USE_PARITY = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PARITY = (PARITY == 1);

  state_t      state, state_nxt;
  logic [13:0] cnt, cnt_nxt;
  logic [13:0] div, div_nxt;
  logic [13:0] div_sel;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  data_q, data_nxt;
  logic        tx_nxt, busy_nxt, done_nxt;
  logic        bit_end;
  logic        par_bit;

  // Bit period in sysclk cycles for each baud select; unused codes fall back to 115200.
  always_comb begin
    case (Baud_set)
      3'd0:    div_sel = 14'd10416;
      3'd1:    div_sel = 14'd5208;
      default: div_sel = 14'd434;
    endcase
  end

  assign bit_end = (cnt == div - 14'd1);
  assign par_bit = ODD_PARITY ? ~(^data_q) : (^data_q);

  // Next-state and next-output logic; the line value for the next cycle is decided here.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 14'd1;
    div_nxt     = div;
    bit_idx_nxt = bit_idx;
    data_nxt    = data_q;
    tx_nxt      = uart_tx;
    busy_nxt    = tx_busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt     = 14'd0;
        bit_idx_nxt = 3'd0;
        tx_nxt      = 1'b1;
        busy_nxt    = 1'b0;
        if (send_en) begin
          state_nxt = START;
          data_nxt  = Data;
          div_nxt   = div_sel;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt   = 14'd0;
          state_nxt = DATA;
          tx_nxt    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = 14'd0;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = 3'd0;
            if (USE_PARITY) begin
              state_nxt = PAR;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = data_q[bit_idx + 3'd1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          cnt_nxt   = 14'd0;
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt   = 14'd0;
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame and forces the line idle.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 14'd0;
      div     <= 14'd0;
      bit_idx <= 3'd0;
      data_q  <= 8'd0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div     <= div_nxt;
      bit_idx <= bit_idx_nxt;
      data_q  <= data_nxt;
      uart_tx <= tx_nxt;
      tx_busy <= busy_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule
